// File: rtl/uart_tx_core.sv
// Byte-wide 8N1 UART transmitter: start bit, eight data bits LSB first, one stop bit.
// Each bit lasts CLOCKS_PER_BAUD clocks; done_o pulses in the last stop-bit cycle.
module uart_tx_core #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output logic       done_o,
    output logic       tx
);

    localparam int CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLOCKS_PER_BAUD - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_done, w_done_nxt;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Next-state and next-output logic; tx/done are computed one cycle ahead so they leave registers.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? '0 : (r_cnt + CW'(1));
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start_i) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = data_i;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = 1'b0;
                end else begin
                    w_tx_nxt    = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_tx_nxt    = 1'b0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // The bit after the current LSB becomes visible as the register shifts
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_STOP: begin
                w_tx_nxt   = 1'b1;
                w_done_nxt = (r_cnt == CNT_PRE);
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign tx     = r_tx;
    assign done_o = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: two instances (C=33 and C=2) compared cycle by cycle
// against a frame-level model built from acceptance offsets and byte values.
module tb_uart_tx_core;

    localparam int C_A = 33;
    localparam int C_B = 2;

    logic       clk = 1'b0;
    logic       rst_a, start_a, done_a, tx_a;
    logic       rst_b, start_b, done_b, tx_b;
    logic [7:0] data_a, data_b;

    int checks = 0;
    int errors = 0;

    logic cap_tx   [0:1023];
    logic cap_done [0:1023];

    int         m_n;
    int         m_off  [0:3];
    logic [7:0] m_byte [0:3];

    always #5 clk = ~clk;

    uart_tx_core #(.CLOCKS_PER_BAUD(C_A)) dut_a (
        .clk(clk), .rst(rst_a), .data_i(data_a), .start_i(start_a), .done_o(done_a), .tx(tx_a)
    );
    uart_tx_core #(.CLOCKS_PER_BAUD(C_B)) dut_b (
        .clk(clk), .rst(rst_b), .data_i(data_b), .start_i(start_b), .done_o(done_b), .tx(tx_b)
    );

    // Line level of bit slot k (0=start, 1..8=data LSB first, 9=stop)
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        else if (k == 9) return 1'b1;
        else return d[k-1];
    endfunction

    // Expected tx in cycle A+j, where frames were accepted at offsets m_off relative to A
    function automatic logic exp_tx(input int j, input int c);
        for (int f = 0; f < m_n; f++)
            if (j - 1 >= m_off[f] && j - 1 < m_off[f] + 10 * c)
                return frame_bit(m_byte[f], (j - 1 - m_off[f]) / c);
        return 1'b1;
    endfunction

    function automatic logic exp_done(input int j, input int c);
        for (int f = 0; f < m_n; f++)
            if (j == m_off[f] + 10 * c) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a negedge: raise start, record n cycles, swap data after acceptance, drop start at hold
    task automatic drive_capture(input int sel, input logic [7:0] d0, input logic [7:0] d1,
                                 input int hold, input int n);
        if (sel == 0) begin data_a = d0; start_a = 1'b1; end
        else          begin data_b = d0; start_b = 1'b1; end
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            cap_tx[j]   = (sel == 0) ? tx_a : tx_b;
            cap_done[j] = (sel == 0) ? done_a : done_b;
            if (j == 1) begin
                if (sel == 0) data_a = d1; else data_b = d1;
            end
            if (j == hold) begin
                if (sel == 0) start_a = 1'b0; else start_b = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b1; start_b = 1'b1;
        data_a = 8'($urandom); data_b = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tx_a !== 1'b1 || done_a !== 1'b0 || tx_b !== 1'b1 || done_b !== 1'b0) begin
                $display("FAIL reset_hold cycle %0d: tx_a=%b done_a=%b tx_b=%b done_b=%b expected tx=1 done=0",
                         i, tx_a, done_a, tx_b, done_b);
                errors++;
            end
        end
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx_a !== 1'b1 || done_a !== 1'b0 || tx_b !== 1'b1 || done_b !== 1'b0) begin
                $display("FAIL reset_release cycle %0d: tx_a=%b done_a=%b tx_b=%b done_b=%b expected tx=1 done=0",
                         i, tx_a, done_a, tx_b, done_b);
                errors++;
            end
        end
    endtask

    task automatic test_single_frame();
        int n;
        n = 10 * C_A + 2;
        m_n = 1; m_off[0] = 0; m_byte[0] = 8'h54;
        drive_capture(0, 8'h54, 8'h54, 1, n);
        for (int j = 1; j <= n; j++) begin
            checks++;
            if (cap_tx[j] !== exp_tx(j, C_A) || cap_done[j] !== exp_done(j, C_A)) begin
                $display("FAIL single_frame cycle A+%0d: tx=%b done=%b expected tx=%b done=%b",
                         j, cap_tx[j], cap_done[j], exp_tx(j, C_A), exp_done(j, C_A));
                errors++;
                break;
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, first_done, second_done;
        n = 2 * 10 * C_A + 3;
        m_n = 2; m_off[0] = 0; m_byte[0] = 8'h54; m_off[1] = 10 * C_A + 1; m_byte[1] = 8'hFF;
        drive_capture(0, 8'h54, 8'hFF, 10 * C_A + 2, n);
        for (int j = 1; j <= n; j++) begin
            checks++;
            if (cap_tx[j] !== exp_tx(j, C_A) || cap_done[j] !== exp_done(j, C_A)) begin
                $display("FAIL back_to_back cycle A+%0d: tx=%b done=%b expected tx=%b done=%b",
                         j, cap_tx[j], cap_done[j], exp_tx(j, C_A), exp_done(j, C_A));
                errors++;
                break;
            end
        end
        first_done = -1; second_done = -1;
        for (int j = 1; j <= n; j++)
            if (cap_done[j] === 1'b1) begin
                if (first_done < 0) first_done = j;
                else if (second_done < 0) second_done = j;
            end
        checks++;
        if (first_done != 330 || second_done - first_done != 331) begin
            $display("FAIL done_spacing: first=%0d gap=%0d expected first=330 gap=331",
                     first_done, second_done - first_done);
            errors++;
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] d;
        int bad;
        d = 8'($urandom);
        data_a = d; start_a = 1'b1;
        for (int j = 1; j <= 4 * C_A + 16; j++) begin
            @(negedge clk);
            if (j == 1) start_a = 1'b0;
        end
        checks++;
        if (tx_a !== d[3]) begin
            $display("FAIL mid_reset_bit3: tx=%b expected %b", tx_a, d[3]);
            errors++;
        end
        rst_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; start_a = 1'b0;
        checks++;
        if (tx_a !== 1'b1 || done_a !== 1'b0) begin
            $display("FAIL mid_reset_next: tx=%b done=%b expected tx=1 done=0", tx_a, done_a);
            errors++;
        end
        bad = 0;
        for (int j = 0; j < 10 * C_A + 5; j++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || done_a !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL mid_reset_abandon: %0d non-idle cycles expected 0", bad);
            errors++;
        end
        d = 8'($urandom);
        m_n = 1; m_off[0] = 0; m_byte[0] = d;
        drive_capture(0, d, d, 1, 10 * C_A + 2);
        for (int j = 1; j <= 10 * C_A + 2; j++) begin
            checks++;
            if (cap_tx[j] !== exp_tx(j, C_A) || cap_done[j] !== exp_done(j, C_A)) begin
                $display("FAIL mid_reset_fresh cycle A+%0d: tx=%b done=%b expected tx=%b done=%b",
                         j, cap_tx[j], cap_done[j], exp_tx(j, C_A), exp_done(j, C_A));
                errors++;
                break;
            end
        end
    endtask

    task automatic test_param_corner();
        m_n = 1; m_off[0] = 0; m_byte[0] = 8'hA5;
        drive_capture(1, 8'hA5, 8'hA5, 1, 10 * C_B + 2);
        for (int j = 1; j <= 10 * C_B + 2; j++) begin
            checks++;
            if (cap_tx[j] !== exp_tx(j, C_B) || cap_done[j] !== exp_done(j, C_B)) begin
                $display("FAIL param_corner cycle A+%0d: tx=%b done=%b expected tx=%b done=%b",
                         j, cap_tx[j], cap_done[j], exp_tx(j, C_B), exp_done(j, C_B));
                errors++;
                break;
            end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d0, d1;
        int c, n;
        for (int i = 0; i < 8; i++) begin
            c = (i % 2 == 0) ? C_B : C_A;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            if (i % 4 == 2) begin
                n = 20 * c + 3;
                m_n = 2; m_off[0] = 0; m_byte[0] = d0; m_off[1] = 10 * c + 1; m_byte[1] = d1;
                drive_capture((c == C_A) ? 0 : 1, d0, d1, 10 * c + 2, n);
            end else begin
                n = 10 * c + 2;
                m_n = 1; m_off[0] = 0; m_byte[0] = d0;
                drive_capture((c == C_A) ? 0 : 1, d0, d1, 1, n);
            end
            for (int j = 1; j <= n; j++) begin
                checks++;
                if (cap_tx[j] !== exp_tx(j, c) || cap_done[j] !== exp_done(j, c)) begin
                    $display("FAIL random_frame %0d (C=%0d) cycle A+%0d: tx=%b done=%b expected tx=%b done=%b",
                             i, c, j, cap_tx[j], cap_done[j], exp_tx(j, c), exp_done(j, c));
                    errors++;
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_mid_frame_reset();
        test_param_corner();
        repeat (2) @(negedge clk);
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Byte-wide UART transmitter (8N1) that serializes one byte per frame onto a single line. The bit period is a whole number of system clocks set by a parameter; at 100 MHz, `CLOCKS_PER_BAUD=33` gives about 3 Mbaud. It sits between a byte producer, which drives a start strobe and data, and the board's serial TX pin. A one-cycle done pulse marks the end of each frame.

## Interface
- `CLOCKS_PER_BAUD`, default 868: clock cycles per bit period; legal range ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_i`  in  8  byte to transmit; sampled only on the cycle a frame is accepted.
- `start_i`  in  1  transmit request; level-sensitive, examined only in IDLE.
- `done_o`  out  1  one-cycle pulse in the final cycle of the stop bit.
- `tx`  out  1  serial line; idles high; registered output.

## Operation
- Frame format: start bit (0), then data bits 0..7 (LSB first), then one stop bit (1). That is 10 bit periods, each `CLOCKS_PER_BAUD` cycles.
- FSM states:
  - IDLE: `tx`=1. If `start_i`=1, latch `data_i` into a shift register, clear the baud counter and bit index, and go to START.
  - START: `tx`=0 for `CLOCKS_PER_BAUD` cycles, then go to DATA.
  - DATA: `tx`=current LSB of the shift register. Shift right every `CLOCKS_PER_BAUD` cycles. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for `CLOCKS_PER_BAUD` cycles. Assert `done_o` in the last cycle, then go to IDLE.
- Baud counter width is `$clog2(CLOCKS_PER_BAUD)`. It counts 0..`CLOCKS_PER_BAUD-1` and wraps at each bit boundary. Bit index is 3 bits.
- `data_i` and `start_i` are ignored outside IDLE. Changing `data_i` mid-frame has no effect on `tx`.
- Holding `start_i` high continuously produces back-to-back frames. There is exactly one idle-high cycle between a frame's stop bit and the next frame's start bit.
- Reset (any state, including mid-frame):
  - Next cycle: IDLE, `tx`=1, `done_o`=0, counters cleared.
  - The in-progress frame is abandoned with no `done_o`.
  - `start_i` on the reset cycle is ignored.
- Reset values: `tx`=1, `done_o`=0.

## Timing
- Cycle A is the edge where IDLE sees `start_i`=1. `tx` falls low after edge A. From there:
  - start bit covers cycles A+1..A+C, where C=`CLOCKS_PER_BAUD`;
  - data bit n covers A+1+(n+1)C .. A+(n+2)C;
  - stop bit covers A+1+9C .. A+10C.
- `done_o`=1 during exactly one cycle, A+10C, which is the last stop-bit cycle. It is 0 at all other times.
- The cycle after `done_o` is IDLE with `tx`=1. If `start_i`=1 there, the next frame is accepted at that edge.
- Frame period with continuous `start_i` is 10C+1 cycles.
- `tx` and `done_o` come from registers, not combinational paths.

## Test plan
- Reset hold:
  - Stimulus: assert `rst` for 5 cycles with `start_i`=1.
  - Response: `tx`=1 and `done_o`=0 throughout; no frame starts until `rst` deasserts.
- Single frame, C=33:
  - Stimulus: `data_i`=0x54, `start_i` high for 1 cycle.
  - Response: `tx` sequence 0, 0,0,1,0,1,0,1,0, 1, each exactly 33 cycles.
  - Response: `done_o` pulses once, 330 cycles after acceptance; `tx`=1 afterwards.
- Data stability:
  - Stimulus: accept 0x54, then change `data_i` to 0xFF on the next cycle and hold `start_i` high.
  - Response: the first frame still carries 0x54.
- Back-to-back frames:
  - Stimulus: continue the data-stability case, keeping `start_i` high one cycle past `done_o`.
  - Response: the second frame carries 0xFF (start 0, eight 1s, stop 1).
  - Response: exactly one idle cycle between frames; second `done_o` 331 cycles after the first.
- Mid-frame reset:
  - Stimulus: assert `rst` for 1 cycle during data bit 3.
  - Response: `tx`=1 next cycle; no `done_o`; a fresh `start_i` then yields a complete frame.
- Parameter corner:
  - Stimulus: C=2, send 0xA5.
  - Response: bits 0,1,0,1,0,0,1,0,1,1, each 2 cycles; `done_o` at cycle A+20.
